// File: rtl/cdb_arbiter_if.sv
// Completion-bus bundle between functional units, the CDB arbiter and the CDB consumers.
// Modport master is the arbiter side; slave is the surrounding core/testbench side.
interface cdb_arbiter_if #(
    parameter int FU_NUM  = 4,
    parameter int PHYS_W  = 6,
    parameter int ROB_W   = 5,
    parameter int EPOCH_W = 2,
    parameter int XLEN    = 32
);
    logic [FU_NUM-1:0]              fu_valid;
    logic [FU_NUM-1:0]              fu_ready;
    logic [FU_NUM-1:0][PHYS_W-1:0]  fu_pd;
    logic [FU_NUM-1:0]              fu_has_dest;
    logic [FU_NUM-1:0][XLEN-1:0]    fu_data;
    logic [FU_NUM-1:0][ROB_W-1:0]   fu_rob_idx;
    logic [FU_NUM-1:0][EPOCH_W-1:0] fu_epoch;

    logic                           wb_valid;
    logic                           wb_ready;
    logic [PHYS_W-1:0]              wb_pd;
    logic                           wb_has_dest;
    logic [XLEN-1:0]                wb_data;
    logic [ROB_W-1:0]               wb_rob_idx;
    logic [EPOCH_W-1:0]             wb_epoch;

    logic                           flush_valid;
    logic                           recover_valid;
    logic [ROB_W-1:0]               recover_rob_idx;
    logic [EPOCH_W-1:0]             recover_epoch;
    logic                           busy;

    modport master (
        input  fu_valid, fu_pd, fu_has_dest, fu_data, fu_rob_idx, fu_epoch,
        output fu_ready,
        output wb_valid, wb_pd, wb_has_dest, wb_data, wb_rob_idx, wb_epoch,
        input  wb_ready,
        input  flush_valid, recover_valid, recover_rob_idx, recover_epoch,
        output busy
    );

    modport slave (
        output fu_valid, fu_pd, fu_has_dest, fu_data, fu_rob_idx, fu_epoch,
        input  fu_ready,
        input  wb_valid, wb_pd, wb_has_dest, wb_data, wb_rob_idx, wb_epoch,
        output wb_ready,
        output flush_valid, recover_valid, recover_rob_idx, recover_epoch,
        input  busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin grant with a stall lock,
// flush and ROB-index/epoch recovery kill.
module cdb_arbiter #(
    parameter int FU_NUM  = 4,
    parameter int PHYS_W  = 6,
    parameter int ROB_W   = 5,
    parameter int EPOCH_W = 2,
    parameter int XLEN    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.master bus
);
    localparam int IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [FU_NUM-1:0]  r_hold_valid;
    logic [PHYS_W-1:0]  r_pd       [FU_NUM];
    logic               r_has_dest [FU_NUM];
    logic [XLEN-1:0]    r_data     [FU_NUM];
    logic [ROB_W-1:0]   r_rob_idx  [FU_NUM];
    logic [EPOCH_W-1:0] r_epoch    [FU_NUM];
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_lock_idx;
    logic               r_locked;

    logic [IDX_W-1:0]   w_grant;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic               w_wb_valid;
    logic               w_hs;
    logic [FU_NUM-1:0]  w_fu_ready;
    logic [FU_NUM-1:0]  w_kill;
    logic [FU_NUM-1:0]  w_take;

    // A locked grant is never displaced by newer arrivals until handshake, flush or kill.
    always_comb begin
        w_grant = r_rr_ptr;
        w_cand  = '0;
        w_found = 1'b0;
        if (r_locked) begin
            w_grant = r_lock_idx;
        end else begin
            for (int unsigned i = 0; i < FU_NUM; i++) begin
                w_cand = IDX_W'((32'(r_rr_ptr) + i) % FU_NUM);
                if (!w_found && r_hold_valid[w_cand]) begin
                    w_grant = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_wb_valid = |r_hold_valid;
    assign w_hs       = w_wb_valid && bus.wb_ready;

    always_comb begin
        bus.wb_pd       = '0;
        bus.wb_has_dest = 1'b0;
        bus.wb_data     = '0;
        bus.wb_rob_idx  = '0;
        bus.wb_epoch    = '0;
        if (w_wb_valid) begin
            bus.wb_pd       = r_pd[w_grant];
            bus.wb_has_dest = r_has_dest[w_grant];
            bus.wb_data     = r_data[w_grant];
            bus.wb_rob_idx  = r_rob_idx[w_grant];
            bus.wb_epoch    = r_epoch[w_grant];
        end
    end

    always_comb begin
        w_fu_ready = '0;
        w_kill     = '0;
        w_take     = '0;
        for (int unsigned f = 0; f < FU_NUM; f++) begin
            w_fu_ready[f] = bus.flush_valid || !r_hold_valid[f] ||
                            (w_hs && (w_grant == IDX_W'(f)));
            w_kill[f]     = bus.recover_valid && r_hold_valid[f] &&
                            (r_rob_idx[f] == bus.recover_rob_idx) &&
                            (r_epoch[f] == bus.recover_epoch);
            // Completions already doomed by a same-cycle recovery are accepted but discarded.
            w_take[f]     = bus.fu_valid[f] && w_fu_ready[f] &&
                            !(bus.recover_valid &&
                              (bus.fu_rob_idx[f] == bus.recover_rob_idx) &&
                              (bus.fu_epoch[f] == bus.recover_epoch));
        end
    end

    assign bus.fu_ready = w_fu_ready;
    assign bus.wb_valid = w_wb_valid;
    assign bus.busy     = w_wb_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            r_lock_idx   <= '0;
            r_locked     <= 1'b0;
            for (int unsigned f = 0; f < FU_NUM; f++) begin
                r_pd[f]       <= '0;
                r_has_dest[f] <= 1'b0;
                r_data[f]     <= '0;
                r_rob_idx[f]  <= '0;
                r_epoch[f]    <= '0;
            end
        end else if (bus.flush_valid) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            r_locked     <= 1'b0;
        end else begin
            for (int unsigned f = 0; f < FU_NUM; f++) begin
                if (w_take[f]) begin
                    r_hold_valid[f] <= 1'b1;
                    r_pd[f]         <= bus.fu_pd[f];
                    r_has_dest[f]   <= bus.fu_has_dest[f];
                    r_data[f]       <= bus.fu_data[f];
                    r_rob_idx[f]    <= bus.fu_rob_idx[f];
                    r_epoch[f]      <= bus.fu_epoch[f];
                end else if (w_kill[f] || (w_hs && (w_grant == IDX_W'(f)))) begin
                    r_hold_valid[f] <= 1'b0;
                end
            end
            if (w_hs) begin
                r_rr_ptr <= (w_grant == IDX_W'(FU_NUM - 1)) ? '0 : w_grant + 1'b1;
                r_locked <= 1'b0;
            end else if (w_wb_valid) begin
                r_locked   <= !w_kill[w_grant];
                r_lock_idx <= w_grant;
            end
        end
    end
endmodule
